// File: rtl/register_block_with_ro.sv
// Register file: DEPTH host-writable control registers plus DEPTH_RO status registers loaded in parallel from fabric.
// Latency: write visible on o_mem one edge after the strobe; read data and valid one edge after i_r_en.
// Backpressure: none; every strobe is accepted on the edge that samples it.
//
// Ports:
//   clk        : single clock, all state updates on the rising edge
//   reset      : asynchronous active-low reset, clears every register and the read port
//   i_w_en     : write strobe for the RW bank
//   i_w_addr   : RW index for the write (codes >= DEPTH are dropped)
//   i_w_value  : write data
//   i_r_en     : read strobe
//   i_r_addr   : unified read address, RW at 0..DEPTH-1, RO at DEPTH..DEPTH+DEPTH_RO-1, 0 above
//   o_r_value  : registered read data, holds between reads
//   o_r_valid  : one-cycle pulse per read strobe
//   o_mem      : live RW bank contents, one element per register
//   i_mem_ro   : parallel load data for the RO bank
//   i_wro_en   : load strobe for the RO bank
module register_block_with_ro #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter int DEPTH_RO = 4,
    // A one-entry bank still needs a one-bit address port.
    localparam int WAW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int RAW = ((DEPTH + DEPTH_RO) > 1) ? $clog2(DEPTH + DEPTH_RO) : 1
) (
    input  logic                               clk,
    input  logic                               reset,

    input  logic                               i_w_en,
    input  logic [WAW-1:0]                     i_w_addr,
    input  logic [WIDTH-1:0]                   i_w_value,

    input  logic                               i_r_en,
    input  logic [RAW-1:0]                     i_r_addr,
    output logic [WIDTH-1:0]                   o_r_value,
    output logic                               o_r_valid,

    output logic [DEPTH-1:0][WIDTH-1:0]        o_mem,

    input  logic [DEPTH_RO-1:0][WIDTH-1:0]     i_mem_ro,
    input  logic                               i_wro_en
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DEPTH-1:0][WIDTH-1:0]    rw_q,      rw_d;
    logic [DEPTH_RO-1:0][WIDTH-1:0] ro_q,      ro_d;
    logic [WIDTH-1:0]               r_value_q, r_value_d;
    logic                           r_valid_q, r_valid_d;

    // Combinational read selection from the current (pre-edge) bank contents.
    logic [WIDTH-1:0]               rd_sel_dat;

    // ------------------------------------------------------------------
    // RW bank next state: single write port, out-of-range indices dropped.
    // ------------------------------------------------------------------
    always_comb begin
        rw_d = rw_q;
        if (i_w_en) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (32'(i_w_addr) == k) begin
                    rw_d[k] = i_w_value;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // RO bank next state: all entries captured together, else hold.
    // ------------------------------------------------------------------
    always_comb begin
        ro_d = ro_q;
        if (i_wro_en) begin
            ro_d = i_mem_ro;
        end
    end

    // ------------------------------------------------------------------
    // Unified read mux. It looks at the _q copies, so a read colliding
    // with a write or RO load on the same edge returns the old contents.
    // Codes beyond the RO bank return zero.
    // ------------------------------------------------------------------
    always_comb begin
        rd_sel_dat = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (32'(i_r_addr) == k) begin
                rd_sel_dat = rw_q[k];
            end
        end
        for (int k = 0; k < DEPTH_RO; k++) begin
            if (32'(i_r_addr) == (DEPTH + k)) begin
                rd_sel_dat = ro_q[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port next state: data holds when no strobe, valid follows strobe.
    // ------------------------------------------------------------------
    always_comb begin
        r_value_d = r_value_q;
        r_valid_d = i_r_en;
        if (i_r_en) begin
            r_value_d = rd_sel_dat;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rw_q      <= '0;
            ro_q      <= '0;
            r_value_q <= '0;
            r_valid_q <= 1'b0;
        end else begin
            rw_q      <= rw_d;
            ro_q      <= ro_d;
            r_value_q <= r_value_d;
            r_valid_q <= r_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs straight from flops.
    // ------------------------------------------------------------------
    assign o_mem     = rw_q;
    assign o_r_value = r_value_q;
    assign o_r_valid = r_valid_q;

endmodule

// File: tb/tb_register_block_with_ro.sv
// Directed bench for register_block_with_ro with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// The DUT has no backpressure, so every step is a fixed number of clocks.
module tb_register_block_with_ro;

    localparam int WIDTH    = 16;
    localparam int DEPTH    = 4;
    localparam int DEPTH_RO = 4;
    localparam int WAW      = $clog2(DEPTH);
    localparam int RAW      = $clog2(DEPTH + DEPTH_RO);

    logic                           clk;
    logic                           reset;
    logic                           i_w_en;
    logic [WAW-1:0]                 i_w_addr;
    logic [WIDTH-1:0]               i_w_value;
    logic                           i_r_en;
    logic [RAW-1:0]                 i_r_addr;
    logic [WIDTH-1:0]               o_r_value;
    logic                           o_r_valid;
    logic [DEPTH-1:0][WIDTH-1:0]    o_mem;
    logic [DEPTH_RO-1:0][WIDTH-1:0] i_mem_ro;
    logic                           i_wro_en;

    int n_checks = 0;
    int n_errors = 0;

    // Hand-computed expected contents for the back-to-back sweeps.
    logic [WIDTH-1:0] exp_sweep [8];

    register_block_with_ro #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .DEPTH_RO (DEPTH_RO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_w_en    (i_w_en),
        .i_w_addr  (i_w_addr),
        .i_w_value (i_w_value),
        .i_r_en    (i_r_en),
        .i_r_addr  (i_r_addr),
        .o_r_value (o_r_value),
        .o_r_valid (o_r_valid),
        .o_mem     (o_mem),
        .i_mem_ro  (i_mem_ro),
        .i_wro_en  (i_wro_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_mem(input string tag, input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                           input logic [WIDTH-1:0] e2, input logic [WIDTH-1:0] e3);
        chk({tag, "_mem0"}, 32'(o_mem[0]), 32'(e0));
        chk({tag, "_mem1"}, 32'(o_mem[1]), 32'(e1));
        chk({tag, "_mem2"}, 32'(o_mem[2]), 32'(e2));
        chk({tag, "_mem3"}, 32'(o_mem[3]), 32'(e3));
    endtask

    // One read strobe, result checked one edge later; strobe dropped afterwards.
    task automatic read_one(input string tag, input int addr, input logic [WIDTH-1:0] exp);
        @(negedge clk);
        i_r_en   = 1'b1;
        i_r_addr = RAW'(addr);
        tick();
        chk({tag, "_valid"}, 32'(o_r_valid), 32'd1);
        chk({tag, "_data"},  32'(o_r_value), 32'(exp));
        @(negedge clk);
        i_r_en = 1'b0;
    endtask

    // Eight reads on consecutive cycles; valid must stay high, data in order.
    task automatic sweep(input string tag);
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            i_r_en   = 1'b1;
            i_r_addr = RAW'(a);
            tick();
            chk($sformatf("%s_v%0d", tag, a), 32'(o_r_valid), 32'd1);
            chk($sformatf("%s_d%0d", tag, a), 32'(o_r_value), 32'(exp_sweep[a]));
        end
        @(negedge clk);
        i_r_en = 1'b0;
        tick();
        chk({tag, "_valid_drop"}, 32'(o_r_valid), 32'd0);
        chk({tag, "_hold"},       32'(o_r_value), 32'(exp_sweep[7]));
    endtask

    initial begin
        reset     = 1'b0;
        i_w_en    = 1'b0;
        i_w_addr  = '0;
        i_w_value = '0;
        i_r_en    = 1'b0;
        i_r_addr  = '0;
        i_mem_ro  = '0;
        i_wro_en  = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) tick();
        chk("rst_valid", 32'(o_r_valid), 32'd0);
        chk("rst_value", 32'(o_r_value), 32'd0);
        chk_mem("rst", 16'h0, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        reset = 1'b1;

        // ---------------- RW writes, one per cycle ----------------
        @(negedge clk);
        i_w_en = 1'b1; i_w_addr = 2'd0; i_w_value = 16'h1111;
        tick();
        chk_mem("w0", 16'h1111, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        i_w_addr = 2'd1; i_w_value = 16'h2222;
        tick();
        chk_mem("w1", 16'h1111, 16'h2222, 16'h0, 16'h0);
        @(negedge clk);
        i_w_addr = 2'd2; i_w_value = 16'h3333;
        tick();
        chk_mem("w2", 16'h1111, 16'h2222, 16'h3333, 16'h0);
        @(negedge clk);
        i_w_addr = 2'd3; i_w_value = 16'h4444;
        tick();
        chk_mem("w3", 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        @(negedge clk);
        i_w_en = 1'b0;

        // Single read: valid for one cycle, data holds afterwards.
        read_one("rd0", 0, 16'h1111);
        tick();
        chk("rd0_pulse_end", 32'(o_r_valid), 32'd0);
        chk("rd0_hold",      32'(o_r_value), 32'h1111);

        // ---------------- RO load ----------------
        @(negedge clk);
        i_mem_ro[0] = 16'h0123;
        i_mem_ro[1] = 16'h4567;
        i_mem_ro[2] = 16'h89ab;
        i_mem_ro[3] = 16'hcdef;
        i_wro_en    = 1'b1;
        tick();
        @(negedge clk);
        i_wro_en = 1'b0;
        read_one("ro6", 6, 16'h89ab);
        read_one("ro4", 4, 16'h0123);
        chk_mem("ro_nomem", 16'h1111, 16'h2222, 16'h3333, 16'h4444);

        // RO hold: new fabric data without the load strobe is ignored.
        @(negedge clk);
        i_mem_ro[3] = 16'h5a5a;
        i_mem_ro[0] = 16'ha5a5;
        repeat (2) tick();
        read_one("ro_hold7", 7, 16'hcdef);

        // ---------------- same-cycle collisions ----------------
        // RW write + read of the same register, plus an RO load + read in the
        // neighbouring cycle pattern: both reads see pre-edge contents.
        @(negedge clk);
        i_w_en = 1'b1; i_w_addr = 2'd1; i_w_value = 16'hBEEF;
        i_r_en = 1'b1; i_r_addr = 3'd1;
        i_mem_ro[1] = 16'h7777;
        i_wro_en    = 1'b1;
        tick();
        chk("coll_rw_old",  32'(o_r_value), 32'h2222);
        chk("coll_rw_mem1", 32'(o_mem[1]),  32'hBEEF);
        @(negedge clk);
        i_w_en = 1'b0; i_wro_en = 1'b0; i_r_en = 1'b0;
        read_one("coll_rw_new", 1, 16'hBEEF);
        // The RO load took effect in the same cycle as the write.
        read_one("coll_ro_both", 5, 16'h7777);

        // RO load + read of that RO register in the same cycle.
        @(negedge clk);
        i_mem_ro[2] = 16'h1234;
        i_wro_en = 1'b1;
        i_r_en   = 1'b1; i_r_addr = 3'd6;
        tick();
        chk("coll_ro_old", 32'(o_r_value), 32'h89ab);
        @(negedge clk);
        i_wro_en = 1'b0; i_r_en = 1'b0;
        read_one("coll_ro_new", 6, 16'h1234);

        // ---------------- back-to-back sweep 0..7 ----------------
        // RO bank now holds the last loaded vector {a5a5,7777,1234,5a5a}.
        exp_sweep[0] = 16'h1111; exp_sweep[1] = 16'hBEEF;
        exp_sweep[2] = 16'h3333; exp_sweep[3] = 16'h4444;
        exp_sweep[4] = 16'ha5a5; exp_sweep[5] = 16'h7777;
        exp_sweep[6] = 16'h1234; exp_sweep[7] = 16'h5a5a;
        sweep("b2b");

        // ---------------- asynchronous reset mid-operation ----------------
        @(negedge clk);
        i_r_en = 1'b1; i_r_addr = 3'd3;
        i_w_en = 1'b1; i_w_addr = 2'd2; i_w_value = 16'hFFFF;
        i_wro_en = 1'b1;
        tick();
        chk("pre_rst_valid", 32'(o_r_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(o_r_valid), 32'd0);
        chk("arst_value", 32'(o_r_value), 32'd0);
        chk_mem("arst", 16'h0, 16'h0, 16'h0, 16'h0);
        // Strobes are still active across this edge but reset holds everything.
        tick();
        chk("arst_hold_valid", 32'(o_r_valid), 32'd0);
        chk_mem("arst_hold", 16'h0, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        i_r_en = 1'b0; i_w_en = 1'b0; i_wro_en = 1'b0;
        reset = 1'b1;

        for (int a = 0; a < 8; a++) exp_sweep[a] = '0;
        sweep("post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/register_block_with_ro.md
# register_block_with_ro

Parameterised register file with two banks: DEPTH read/write registers loaded through a single write port, and DEPTH_RO read-only registers captured in parallel from fabric inputs. Both banks are read back through one unified, registered read port. The RW bank is also exported continuously as a parallel array to drive control logic. It sits between a host/bus interface (write/read ports) and the datapath (o_mem controls, i_mem_ro status).

## Interface
- WIDTH, 16: register width in bits.
- DEPTH, 4: number of RW registers (≥1).
- DEPTH_RO, 4: number of RO registers (≥1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- i_w_en  in  1  write strobe for the RW bank.
- i_w_addr  in  $clog2(DEPTH)  RW register index for the write.
- i_w_value  in  WIDTH  write data.
- i_r_en  in  1  read strobe.
- i_r_addr  in  $clog2(DEPTH+DEPTH_RO)  unified read address.
- o_r_value  out  WIDTH  registered read data.
- o_r_valid  out  1  one-cycle pulse qualifying o_r_value.
- o_mem  out  WIDTH x [DEPTH]  current contents of the RW bank, one element per register.
- i_mem_ro  in  WIDTH x [DEPTH_RO]  parallel load data for the RO bank.
- i_wro_en  in  1  load strobe for the RO bank.

## Operation
- Address map (read): 0..DEPTH-1 → RW[addr]; DEPTH..DEPTH+DEPTH_RO-1 → RO[addr-DEPTH]; any higher code → data 0, o_r_valid still asserted.
- Write: on a rising edge with i_w_en=1, RW[i_w_addr] ← i_w_value. If i_w_addr ≥ DEPTH, the write is ignored. Host writes cannot reach the RO bank.
- RO load: on a rising edge with i_wro_en=1, RO[k] ← i_mem_ro[k] for all k simultaneously. Otherwise the RO bank holds its value.
- o_mem[k] is driven directly from RW[k] through a flop output, with no extra combinational logic.
- Read: on a rising edge with i_r_en=1, o_r_value ← selected register and o_r_valid ← 1. On an edge with i_r_en=0, o_r_valid ← 0 and o_r_value holds its last value.
- Simultaneous write and read of the same RW register: the read returns the pre-write value.
- Simultaneous RO load and read of an RO register: the read returns the pre-load value.
- Write and RO load in the same cycle are independent and both take effect.
- Reset (reset=0, asynchronous): all RW and RO registers, o_r_value and o_r_valid clear to 0 immediately. Reset overrides any in-flight access. Strobes are ignored while reset is held.

## Timing
- Write → visible on o_mem: 1 edge (updates at the edge that samples i_w_en).
- Write → readable: a read issued on the cycle after the write edge returns the new data.
- Read latency: 1 cycle. Data and valid update at the edge sampling i_r_en. o_r_valid is high for exactly one cycle per strobe cycle.
- Back-to-back reads: one result per cycle, no bubbles.
- RO load → readable: the next read strobe after the load edge.
- No backpressure and no handshake beyond the strobes.

## Test plan
- Reset: drive reset=0 mid-operation → o_mem all 0, o_r_valid=0, o_r_value=0 immediately; reading addresses 0–7 after release returns 0.
- RW write/readback: write 0x1111, 0x2222, 0x3333, 0x4444 to addresses 0–3 on consecutive cycles → o_mem matches each one edge later; reading address 0 gives 0x1111 with a single valid pulse, 1 cycle after the strobe.
- RO load: i_mem_ro={0x0123,0x4567,0x89ab,0xcdef}, i_wro_en one cycle → read address 6 returns 0x89ab; address 4 returns 0x0123; o_mem unchanged.
- RO hold: change i_mem_ro with i_wro_en=0 → read address 7 still returns 0xcdef.
- Same-cycle collision: write 0xBEEF to address 1 while reading address 1 → read returns the old value 0x2222; the next read returns 0xBEEF.
- Back-to-back reads of addresses 0..7 → eight consecutive valid cycles with the correct data in order.
